// File: rtl/i2s_rx.sv
// Slave-mode I2S receiver: oversamples BCK/LRCK/DIN on clk, frames left/right
// slots with the one-bit I2S delay and publishes sample pairs via valid/ready.
//
// state    | meaning
// ST_HUNT  | waiting for an lrck 1->0 change event, nothing captured
// ST_LEFT  | capturing the left slot
// ST_RIGHT | capturing the right slot; its close completes a frame
module i2s_rx #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i2s_bck,
    input  logic             i2s_lrck,
    input  logic             i2s_din,
    output logic [WIDTH-1:0] left_data,
    output logic [WIDTH-1:0] right_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             frame_lock,
    output logic             err_overrun,
    output logic             err_short,
    input  logic             err_clr
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    logic [2:0]       bck_sync_q;
    logic [1:0]       lrck_sync_q, din_sync_q;
    logic             lrck_prev_q, lrck_prev_d;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [WIDTH-1:0] left_hold_q, left_hold_d;
    logic [WIDTH-1:0] left_q, left_d, right_q, right_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d, short_q, short_d;

    logic             bck_evt, lrck_s, din_s, lr_change;
    logic [WIDTH-1:0] word_w;
    logic [CW-1:0]    cnt_w;
    logic             frame_done, slot_short, accept;

    assign bck_evt   = bck_sync_q[1] & ~bck_sync_q[2];
    assign lrck_s    = lrck_sync_q[1];
    assign din_s     = din_sync_q[1];
    assign lr_change = lrck_s ^ lrck_prev_q;
    assign accept    = valid_q & sample_ready;

    // Bits land at their final position so a short slot ends up left-justified.
    always_comb begin
        word_w = shift_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(WIDTH - 1 - i)) word_w[i] = din_s;
        end
        cnt_w = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CW'(1);
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        lrck_prev_d = lrck_prev_q;
        left_hold_d = left_hold_q;
        frame_done  = 1'b0;
        slot_short  = 1'b0;
        if (bck_evt) begin
            tmo_d       = TMO_LOAD;
            lrck_prev_d = lrck_s;
            case (state_q)
                ST_HUNT: begin
                    if (lr_change && !lrck_s) begin
                        state_d = ST_LEFT;
                        shift_d = '0;
                        cnt_d   = '0;
                    end
                end
                ST_LEFT, ST_RIGHT: begin
                    if (lr_change) begin
                        slot_short = (cnt_w < CNT_FULL);
                        shift_d    = '0;
                        cnt_d      = '0;
                        if (state_q == ST_LEFT) begin
                            left_hold_d = word_w;
                            state_d     = ST_RIGHT;
                        end else begin
                            frame_done = 1'b1;
                            state_d    = ST_LEFT;
                        end
                    end else begin
                        shift_d = word_w;
                        cnt_d   = cnt_w;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end else if (tmo_q == '0) begin
            state_d = ST_HUNT;
            shift_d = '0;
            cnt_d   = '0;
        end else begin
            tmo_d = tmo_q - TW'(1);
        end
    end

    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        valid_d = valid_q;
        ovr_d   = err_clr ? 1'b0 : ovr_q;
        short_d = (err_clr ? 1'b0 : short_q) | slot_short;
        if (frame_done) begin
            if (!valid_q || accept) begin
                left_d  = left_hold_q;
                right_d = word_w;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_sync_q  <= '0;
            lrck_sync_q <= '0;
            din_sync_q  <= '0;
            lrck_prev_q <= 1'b0;
            state_q     <= ST_HUNT;
            shift_q     <= '0;
            cnt_q       <= '0;
            tmo_q       <= TMO_LOAD;
            left_hold_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            bck_sync_q  <= {bck_sync_q[1:0], i2s_bck};
            lrck_sync_q <= {lrck_sync_q[0], i2s_lrck};
            din_sync_q  <= {din_sync_q[0], i2s_din};
            lrck_prev_q <= lrck_prev_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            left_hold_q <= left_hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            short_q     <= short_d;
        end
    end

    assign left_data    = left_q;
    assign right_data   = right_q;
    assign sample_valid = valid_q;
    assign frame_lock   = (state_q != ST_HUNT);
    assign err_overrun  = ovr_q;
    assign err_short    = short_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: directed vector table, handshake/fault
// sequences, then random frames scored against a slot-level reference model.
module tb_i2s_rx;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 256;

    logic clk = 1'b0, rst_n = 1'b0;
    logic bck = 1'b0, lrck = 1'b0, din = 1'b0;
    logic ready = 1'b0, err_clr = 1'b0;
    logic [WIDTH-1:0] left_data, right_data;
    logic sample_valid, frame_lock, err_overrun, err_short;

    i2s_rx #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i2s_bck(bck), .i2s_lrck(lrck), .i2s_din(din),
        .left_data(left_data), .right_data(right_data),
        .sample_valid(sample_valid), .sample_ready(ready),
        .frame_lock(frame_lock), .err_overrun(err_overrun),
        .err_short(err_short), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int bck_lo = 3, bck_hi = 3;
    bit mon_en = 1'b0;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } frame_t;
    frame_t exp_q[$];

    typedef struct {
        logic [31:0] lw;
        logic [31:0] rw;
        int          ln;
        int          rn;
        logic [15:0] el;
        logic [15:0] er;
        logic        es;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a slot keeps its first min(n,16) bits, MSB first, left-justified.
    function automatic logic [15:0] exp_word(input logic [31:0] w, input int n);
        int t;
        logic [31:0] v;
        t = (n < 16) ? n : 16;
        v = (w >> (32 - t)) << (16 - t);
        return v[15:0];
    endfunction

    task automatic send_bit(input logic lr, input logic d);
        lrck = lr;
        din  = d;
        repeat (bck_lo) @(negedge clk);
        bck = 1'b1;
        repeat (bck_hi) @(negedge clk);
        bck = 1'b0;
    endtask

    // Slot bits go out MSB first from w; the last bit carries the next slot's lrck.
    task automatic send_slot(input logic ch, input logic [31:0] w, input int n, input logic nxt);
        for (int i = 0; i < n; i++)
            send_bit((i == n - 1) ? nxt : ch, (i < 32) ? w[31 - i] : 1'b0);
    endtask

    task automatic preamble();
        send_slot(1'b1, 32'h0, 3, 1'b0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic idle_to_hunt();
        repeat (TIMEOUT + 40) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en && sample_valid && ready) begin
            if (exp_q.size() > 0) begin
                chk("rand_left", left_data, exp_q[0].l);
                chk("rand_right", right_data, exp_q[0].r);
                void'(exp_q.pop_front());
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_unexpected_publish: got %0h/%0h expected none", left_data, right_data);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_short;
        int ln, rn;
        logic [31:0] lw, rw;

        tbl[0] = '{32'hA5C3_0000, 32'h1234_0000, 16, 16, 16'hA5C3, 16'h1234, 1'b0};
        tbl[1] = '{32'hDEAD_BEEF, 32'h0000_FFFF, 32, 32, 16'hDEAD, 16'h0000, 1'b0};
        tbl[2] = '{32'hABC0_0000, 32'h5670_0000, 12, 12, 16'hABC0, 16'h5670, 1'b1};
        tbl[3] = '{32'h8001_8000, 32'hFFFF_FFFF, 17, 31, 16'h8001, 16'hFFFF, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_valid", sample_valid, 0);
        chk("rst_left", left_data, 0);
        chk("rst_right", right_data, 0);
        chk("rst_lock", frame_lock, 0);
        chk("rst_ovr", err_overrun, 0);
        chk("rst_short", err_short, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            pulse_clr();
            preamble();
            send_slot(1'b0, tbl[k].lw, tbl[k].ln, 1'b1);
            if (k == 0) begin
                send_slot(1'b1, tbl[k].rw, tbl[k].rn - 1, 1'b1);
                lrck = 1'b0;
                din  = tbl[k].rw[31 - (tbl[k].rn - 1)];
                repeat (bck_lo) @(negedge clk);
                bck = 1'b1;
                @(negedge clk);
                chk("lat_edge1_valid", sample_valid, 0);
                @(negedge clk);
                chk("lat_edge2_valid", sample_valid, 0);
                @(negedge clk);
                chk("lat_edge3_valid", sample_valid, 1);
                repeat (bck_hi - 3) @(negedge clk);
                bck = 1'b0;
            end else begin
                send_slot(1'b1, tbl[k].rw, tbl[k].rn, 1'b0);
            end
            @(negedge clk);
            chk("vec_valid", sample_valid, 1);
            chk("vec_left", left_data, tbl[k].el);
            chk("vec_right", right_data, tbl[k].er);
            chk("vec_short", err_short, tbl[k].es);
            chk("vec_ovr", err_overrun, 0);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            chk("vec_valid_drop", sample_valid, 0);
            idle_to_hunt();
        end

        // Overrun: two frames arrive with no consumer.
        pulse_clr();
        preamble();
        send_slot(1'b0, 32'h1111_0000, 16, 1'b1);
        send_slot(1'b1, 32'h2222_0000, 16, 1'b0);
        send_slot(1'b0, 32'h3333_0000, 16, 1'b1);
        send_slot(1'b1, 32'h4444_0000, 16, 1'b0);
        @(negedge clk);
        chk("ovr_left", left_data, 16'h1111);
        chk("ovr_right", right_data, 16'h2222);
        chk("ovr_valid", sample_valid, 1);
        chk("ovr_flag", err_overrun, 1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("ovr_one_transfer", sample_valid, 0);
        pulse_clr();
        chk("ovr_cleared", err_overrun, 0);

        // Accept on the very cycle a new frame completes.
        send_slot(1'b0, 32'hAAAA_0000, 16, 1'b1);
        send_slot(1'b1, 32'hBBBB_0000, 16, 1'b0);
        @(negedge clk);
        chk("same_pre_left", left_data, 16'hAAAA);
        send_slot(1'b0, 32'hCCCC_0000, 16, 1'b1);
        send_slot(1'b1, 32'hDDDD_0000, 15, 1'b1);
        lrck = 1'b0;
        din  = 1'b1;
        repeat (bck_lo) @(negedge clk);
        bck = 1'b1;
        repeat (2) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("same_valid", sample_valid, 1);
        chk("same_left", left_data, 16'hCCCC);
        chk("same_right", right_data, 16'hDDDD);
        chk("same_ovr", err_overrun, 0);
        repeat (bck_hi - 3) @(negedge clk);
        bck = 1'b0;

        // BCK stops mid left slot.
        send_slot(1'b0, 32'hF0F0_0000, 5, 1'b0);
        chk("tmo_lock_before", frame_lock, 1);
        repeat (TIMEOUT + 20) @(negedge clk);
        chk("tmo_lock_after", frame_lock, 0);
        send_slot(1'b0, 32'h0F0F_0000, 11, 1'b1);
        send_slot(1'b1, 32'h7777_0000, 16, 1'b0);
        @(negedge clk);
        chk("tmo_no_publish_left", left_data, 16'hCCCC);
        chk("tmo_no_publish_right", right_data, 16'hDDDD);
        chk("tmo_valid_held", sample_valid, 1);

        // Reset mid frame.
        send_slot(1'b0, 32'h9999_0000, 16, 1'b1);
        send_slot(1'b1, 32'h6666_0000, 6, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", sample_valid, 0);
        chk("mid_rst_left", left_data, 0);
        chk("mid_rst_right", right_data, 0);
        chk("mid_rst_lock", frame_lock, 0);
        chk("mid_rst_ovr", err_overrun, 0);
        rst_n = 1'b1;
        @(negedge clk);
        send_slot(1'b1, 32'hFFFF_0000, 5, 1'b0);
        send_slot(1'b0, 32'h5A5A_0000, 16, 1'b1);
        @(negedge clk);
        chk("restart_no_early_valid", sample_valid, 0);
        send_slot(1'b1, 32'hC3C3_0000, 16, 1'b0);
        @(negedge clk);
        chk("restart_valid", sample_valid, 1);
        chk("restart_left", left_data, 16'h5A5A);
        chk("restart_right", right_data, 16'hC3C3);

        // Random frames, consumer always ready.
        ready = 1'b1;
        idle_to_hunt();
        pulse_clr();
        exp_short = 1'b0;
        mon_en = 1'b1;
        preamble();
        for (int f = 0; f < 20; f++) begin
            ln = $urandom_range(8, 34);
            rn = $urandom_range(8, 34);
            lw = $urandom;
            rw = $urandom;
            bck_lo = $urandom_range(2, 4);
            bck_hi = $urandom_range(2, 4);
            exp_q.push_back('{exp_word(lw, ln), exp_word(rw, rn)});
            exp_short = exp_short | (ln < 16) | (rn < 16);
            send_slot(1'b0, lw, ln, 1'b1);
            send_slot(1'b1, rw, rn, 1'b0);
        end
        bck_lo = 3;
        bck_hi = 3;
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        chk("rand_all_published", exp_q.size(), 0);
        chk("rand_short", err_short, exp_short);
        chk("rand_ovr", err_overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
